// File: rtl/multdiv_pkg.sv
// Shared types and sizes for the multdiv unit (multiply side).
package multdiv_pkg;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned MULT_ITER  = MULT_WIDTH / 2;

    // Multiplier sequencing states
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mult_state_e;

    // Radix-4 Booth partial-product selection
    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_sel_e;

endpackage

// File: rtl/booth_multiplier_if.sv
// ctrl/result/RDY handshake between multdiv and the Booth multiplier.
interface booth_multiplier_if
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA,
        output data_operandB,
        output ctrl_MULT,
        input  data_result,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  data_operandA,
        input  data_operandB,
        input  ctrl_MULT,
        output data_result,
        output data_exception,
        output data_resultRDY
    );
endinterface

// File: rtl/booth_encoder.sv
// Radix-4 Booth recoder: 3-bit group selects 0/+-M/+-2M; negation is
// returned as invert-only plus a separate carry-in for the adder.
module booth_encoder
    import multdiv_pkg::*;
#(
    parameter int unsigned MW = MULT_WIDTH + 2
) (
    input  logic [2:0]    group,
    input  logic [MW-1:0] m,
    output logic [MW-1:0] addend,
    output logic          negate
);

    booth_sel_e    sel;
    logic [MW-1:0] mag;

    // Decode the group and build the (possibly inverted) addend
    always_comb begin
        sel = ZERO;
        case (group)
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase

        negate = (sel == NEG1) || (sel == NEG2);

        mag = '0;
        case (sel)
            POS1, NEG1: mag = m;
            POS2, NEG2: mag = {m[MW-2:0], 1'b0};
            default:    mag = '0;
        endcase

        addend = negate ? ~mag : mag;
    end

endmodule

// File: rtl/booth_multiplier.sv
// Iterative signed radix-4 Booth multiplier; one add/shift step per clock,
// low WIDTH bits of the product plus a signed-overflow flag.
module booth_multiplier
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    booth_multiplier_if.slave  bus
);

    localparam int unsigned ITER = WIDTH / 2;
    localparam int unsigned MW   = WIDTH + 2;
    localparam int unsigned PW   = 2 * WIDTH + 3;
    localparam int unsigned CW   = $clog2(ITER) + 1;

    mult_state_e          state;
    mult_state_e          state_next;
    logic                 start;
    logic                 finish;

    logic [MW-1:0]        m;
    logic [PW-1:0]        p;
    logic [PW-1:0]        p_sum;
    logic [PW-1:0]        p_step;
    logic [CW-1:0]        count;
    logic [MW-1:0]        addend;
    logic                 negate;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH:0]       prod_hi;

    booth_encoder #(
        .MW (MW)
    ) u_encoder (
        .group  (p[2:0]),
        .m      (m),
        .addend (addend),
        .negate (negate)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; a new ctrl_MULT always restarts from the load
    always_comb begin
        state_next = state;
        start      = bus.ctrl_MULT;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = BUSY;
            end
            BUSY: begin
                if (start) begin
                    state_next = BUSY;
                end else if (count == CW'(ITER - 1)) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end
            end
            DONE: begin
                state_next = start ? BUSY : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One Booth step: add into the top MW bits, then arithmetic shift by 2
    always_comb begin
        p_sum   = {p[PW-1:WIDTH+1] + addend + MW'(negate), p[WIDTH:0]};
        p_step  = PW'($signed(p_sum) >>> 2);
        product = p_step[2*WIDTH:1];
        prod_hi = product[2*WIDTH-1:WIDTH-1];
    end

    // Operand load, step datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            m                  <= '0;
            p                  <= '0;
            count              <= '0;
            bus.data_result    <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
        end else begin
            bus.data_resultRDY <= finish;
            if (start) begin
                m     <= {{2{bus.data_operandA[WIDTH-1]}}, bus.data_operandA};
                p     <= {MW'(0), bus.data_operandB, 1'b0};
                count <= '0;
            end else if (state == BUSY) begin
                p     <= p_step;
                count <= count + CW'(1);
                if (finish) begin
                    bus.data_result    <= product[WIDTH-1:0];
                    bus.data_exception <= !((&prod_hi) || !(|prod_hi));
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier against a plain-arithmetic model.
module tb_booth_multiplier;
    import multdiv_pkg::*;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;
    int   rdy_count;

    booth_multiplier_if #(.WIDTH(32)) bus ();

    booth_multiplier #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RDY pulses, sampled away from the active edge
    always @(negedge clock) begin
        if (bus.data_resultRDY === 1'b1) rdy_count++;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: full signed product, low word and range test
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc);
        longint sa;
        longint sb;
        longint prod;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        prod = sa * sb;
        res  = 32'(prod);
        exc  = (prod > 64'sd2147483647) || (prod < -64'sd2147483648);
    endtask

    // Pulse ctrl_MULT, verify RDY timing and the result 16 edges later
    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] er;
        logic        ee;
        model(a, b, er, ee);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY !== 1'b0) check({tag, " rdy early"}, 64'(bus.data_resultRDY), 64'd0);
        end
        @(negedge clock);
        check({tag, " rdy"},    64'(bus.data_resultRDY), 64'd1);
        check({tag, " result"}, 64'(bus.data_result),    64'(er));
        check({tag, " exc"},    64'(bus.data_exception), 64'(ee));
        @(negedge clock);
        check({tag, " rdy drop"}, 64'(bus.data_resultRDY), 64'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hold_res;
        logic        hold_exc;
        int          rdy_before;
        int          ops;

        vectors           = 0;
        miscompares       = 0;
        rdy_count         = 0;
        reset             = 1'b1;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) @(negedge clock);
        check("reset result", 64'(bus.data_result),    64'd0);
        check("reset exc",    64'(bus.data_exception), 64'd0);
        check("reset rdy",    64'(bus.data_resultRDY), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed operands, including the overflow corners
        do_mult(32'd7, 32'd6, "7x6");
        check("7x6 const", 64'(bus.data_result), 64'h2A);
        do_mult(-32'sd3, 32'd5, "-3x5");
        check("-3x5 const", 64'(bus.data_result), 64'hFFFF_FFF1);
        do_mult(32'h7FFF_FFFF, 32'd1, "max x1");
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, "-1x-1");
        do_mult(32'h8000_0000, 32'hFFFF_FFFF, "min x-1");
        check("min x-1 exc const", 64'(bus.data_exception), 64'd1);
        do_mult(32'h0001_0000, 32'h0001_0000, "2^16 sq");
        check("2^16 sq exc const", 64'(bus.data_exception), 64'd1);
        do_mult(32'h8000_0000, 32'd1, "min x1");
        check("min x1 exc const", 64'(bus.data_exception), 64'd0);
        do_mult(32'd0, 32'h8000_0000, "0 x min");
        do_mult(32'h8000_0000, 32'h8000_0000, "min x min");

        // Result holds while operand inputs wander
        hold_res = bus.data_result;
        hold_exc = bus.data_exception;
        for (int i = 0; i < 4; i++) begin
            bus.data_operandA = $urandom;
            bus.data_operandB = $urandom;
            @(negedge clock);
        end
        check("hold result", 64'(bus.data_result),    64'(hold_res));
        check("hold exc",    64'(bus.data_exception), 64'(hold_exc));

        // Abort: 2x2 at E0, 9x9 at E8, single RDY after E24
        rdy_before        = rdy_count;
        bus.data_operandA = 32'd2;
        bus.data_operandB = 32'd2;
        bus.ctrl_MULT     = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        repeat (7) @(negedge clock);
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd9;
        bus.ctrl_MULT     = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = 32'd1234;
        bus.data_operandB = 32'd5678;
        repeat (15) @(negedge clock);
        check("abort no early rdy", 64'(rdy_count - rdy_before), 64'd0);
        @(negedge clock);
        check("abort rdy",    64'(bus.data_resultRDY), 64'd1);
        check("abort result", 64'(bus.data_result),    64'h51);
        repeat (4) @(negedge clock);
        check("abort single rdy", 64'(rdy_count - rdy_before), 64'd1);

        // Reset mid-operation at E5, then reset+ctrl together
        rdy_before        = rdy_count;
        bus.data_operandA = 32'd3;
        bus.data_operandB = 32'd4;
        bus.ctrl_MULT     = 1'b1;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset result", 64'(bus.data_result),    64'd0);
        check("midreset exc",    64'(bus.data_exception), 64'd0);
        bus.data_operandA = 32'd5;
        bus.data_operandB = 32'd5;
        bus.ctrl_MULT     = 1'b1;
        @(negedge clock);
        reset         = 1'b0;
        bus.ctrl_MULT = 1'b0;
        repeat (24) @(negedge clock);
        check("reset no rdy", 64'(rdy_count - rdy_before), 64'd0);
        check("reset+ctrl no load", 64'(bus.data_result), 64'd0);
        do_mult(32'd3, 32'd4, "3x4 after reset");
        check("3x4 const", 64'(bus.data_result), 64'hC);

        // Random signed pairs with occasional corner values
        rdy_before = rdy_count;
        ops        = 0;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'h8000_0000;
                1:       a = 32'($signed($urandom_range(0, 64)) - 32);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'hFFFF_FFFF;
                1:       b = $urandom_range(0, 70000);
                default: b = $urandom;
            endcase
            do_mult(a, b, "random");
            ops++;
        end
        check("random rdy count", 64'(rdy_count - rdy_before), 64'(ops));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
